// File: rtl/alu_iterative_exec.sv
// ---------------------------------------------------------------------------
// alu_iterative_exec
//
// Execute-stage ALU. Add/sub, logic and compare ops finish in one cycle.
// Shifts use a one-bit-per-cycle iterative shifter instead of a barrel
// shifter, so requests use a valid/ready handshake.
//
// Ports:
//   i_clk     clock, all state updates on the rising edge
//   i_rst     synchronous active-high reset
//   i_valid   request strobe; op and operands are valid this cycle
//   o_ready   high when a request can be accepted this cycle
//   i_alu_op  4-bit ALU operation code
//   i_data_a  operand A
//   i_data_b  operand B; the low NB_SHAMT bits are the shift amount
//   o_valid   one-cycle pulse; o_result holds a new result
//   o_result  registered result, held until the next completion
//   o_zero    high when o_result is zero
// ---------------------------------------------------------------------------
module alu_iterative_exec #(
    parameter int NB_DATA  = 32,
    parameter int NB_SHAMT = $clog2(NB_DATA)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [3:0]         i_alu_op,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_zero
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state;
    logic [3:0]           shift_op;
    logic [NB_DATA-1:0]   shift_reg;
    logic [NB_SHAMT-1:0]  count;
    logic                 sign_bit;

    logic [NB_SHAMT-1:0]  shamt;
    logic                 is_shift;
    logic [NB_DATA-1:0]   alu_res;
    logic [NB_DATA-1:0]   shift_next;

    assign shamt    = i_data_b[NB_SHAMT-1:0];
    assign is_shift = (i_alu_op == OP_SLL) || (i_alu_op == OP_SRL) ||
                      (i_alu_op == OP_SRA);

    assign o_ready = (state == IDLE);
    assign o_zero  = (o_result == '0);

    // Single-cycle result. A shift only lands here when its amount is zero,
    // in which case the result is simply operand A. Unused codes act as ADD.
    always_comb begin
        alu_res = i_data_a + i_data_b;
        case (i_alu_op)
            OP_ADD:  alu_res = i_data_a + i_data_b;
            OP_SUB:  alu_res = i_data_a - i_data_b;
            OP_SLT:  alu_res = {{(NB_DATA-1){1'b0}},
                                ($signed(i_data_a) < $signed(i_data_b))};
            OP_SLTU: alu_res = {{(NB_DATA-1){1'b0}}, (i_data_a < i_data_b)};
            OP_XOR:  alu_res = i_data_a ^ i_data_b;
            OP_OR:   alu_res = i_data_a | i_data_b;
            OP_AND:  alu_res = i_data_a & i_data_b;
            OP_SLL, OP_SRL, OP_SRA: alu_res = i_data_a;
            default: alu_res = i_data_a + i_data_b;
        endcase
    end

    // One-bit step of the iterative shifter. Right shifts fill with the
    // sign bit captured at accept (SRA) or zero (SRL).
    always_comb begin
        shift_next = {shift_reg[NB_DATA-2:0], 1'b0};
        if (shift_op != OP_SLL) begin
            shift_next = {((shift_op == OP_SRA) & sign_bit),
                          shift_reg[NB_DATA-1:1]};
        end
    end

    // Control FSM. IDLE accepts requests and completes single-cycle ops
    // directly; SHIFT steps the shifter until the counter runs out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            shift_op  <= OP_ADD;
            shift_reg <= '0;
            count     <= '0;
            sign_bit  <= 1'b0;
            o_result  <= '0;
            o_valid   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (is_shift && (shamt != '0)) begin
                            shift_op  <= i_alu_op;
                            shift_reg <= i_data_a;
                            count     <= shamt;
                            sign_bit  <= i_data_a[NB_DATA-1];
                            state     <= SHIFT;
                        end else begin
                            o_result <= alu_res;
                            o_valid  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_next;
                    count     <= count - NB_SHAMT'(1);
                    if (count == NB_SHAMT'(1)) begin
                        o_result <= shift_next;
                        o_valid  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_iterative_exec.md
# alu_iterative_exec

Execute-stage ALU that consumes the 4-bit ALU operation code produced by the ALU control unit, together with two operands, and returns a registered result. Add/sub, logic and compare complete in one cycle. Shifts run on a one-bit-per-cycle iterative shifter that replaces a barrel shifter, so a valid/ready handshake with the pipeline control is required.

## Interface
- NB_DATA, 32, operand/result width; power of two, ≥ 8
- NB_SHAMT, log2(NB_DATA) = 5, shift-amount width
- i_clk  in  1  clock; all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  request strobe; operands and op valid this cycle
- o_ready  out  1  block can accept a request this cycle
- i_alu_op  in  4  operation code (encoding below)
- i_data_a  in  NB_DATA  operand A (rs1)
- i_data_b  in  NB_DATA  operand B (rs2 or immediate); shamt = i_data_b[NB_SHAMT-1:0]
- o_valid  out  1  one-cycle pulse; o_result holds a new result
- o_result  out  NB_DATA  registered result; held until the next completion
- o_zero  out  1  o_result == 0 (combinational from o_result)

## Operation
- Op encoding:
  - 0000 ADD: A+B
  - 0001 SUB: A−B
  - 0010 SLL
  - 0011 SLT: signed A<B
  - 0100 SLTU: unsigned A<B
  - 0101 XOR
  - 0110 SRL
  - 0111 SRA
  - 1000 OR
  - 1001 AND
  - 1010–1111: executed as ADD
- Arithmetic: add/sub modulo 2^NB_DATA, no carry or overflow outputs. SLT/SLTU give 1 or 0, zero-extended.
- Shifts: upper bits of B above NB_SHAMT are ignored. SRL fills with 0. SRA fills with the captured A[NB_DATA-1] on every step.
- FSM states: IDLE, SHIFT.
  - IDLE: o_ready=1. Accept occurs when i_valid && o_ready. Op, A and shamt are captured at the accept edge; later input changes have no effect on that op.
  - IDLE, accept, non-shift op or shamt==0: o_result is written with the result at the accept edge, o_valid=1 for the next cycle, stay IDLE.
  - IDLE, accept, shift op with shamt=n≥1: shift register ← A, counter ← n, go to SHIFT.
  - SHIFT: o_ready=0. Each edge shifts by 1 and decrements the counter. On the edge where the counter goes 1→0, o_result ← final value, o_valid=1 for the next cycle, go to IDLE.
- i_valid while o_ready=0 is ignored, not queued. The requester holds the request until o_ready=1.
- o_ready is high in the cycle o_valid is high, so back-to-back issue is allowed. A new accept in that cycle overwrites o_result at the next completion only.
- o_valid is never high for two consecutive cycles from the same op.

## Timing
- Reset (i_rst=1 at an edge), whether in IDLE or mid-SHIFT:
  - state=IDLE, o_ready=1, o_valid=0, o_result=0, o_zero=1, counter=0.
  - An aborted shift never produces o_valid.
  - i_valid during reset cycles is ignored.
- Latency, accept edge to o_valid high:
  - Non-shift or shamt 0: 1 cycle.
  - Shift n≥1: n+1 cycles. o_ready is low for n cycles.
- Throughput: 1 op/cycle for non-shift ops.
- Maximum shift NB_DATA−1 = 31 gives latency 32.

## Test plan
- Reset mid-shift: A=0x1, B=31, SLL accepted, i_rst asserted after 10 cycles → o_valid never pulses; o_result=0, o_zero=1, o_ready=1 in the cycle after reset. Next ADD 2+3 → o_result=5.
- Back-to-back single-cycle ops: ADD 7+5, SUB 5−7, SLT(0xFFFFFFFF,1), SLTU(0xFFFFFFFF,1), XOR/OR/AND (0xF0F0,0x0FF0), op 1111 (3,4), on consecutive cycles → o_valid every cycle with results in order:
  - 12, 0xFFFFFFFE, 1, 0
  - 0xFF00, 0xFFF0, 0x00F0
  - 7
- Shift timing: SRA A=0x80000000, B=0x24 (shamt 4) → o_ready low 4 cycles, o_valid 5 cycles after accept, o_result=0xF8000000. SRL of the same operands → 0x08000000.
- Shamt zero and upper-B masking: SLL A=0xABCD, B=0x20 → o_result=0xABCD after 1 cycle with no SHIFT state entered. SUB 3−3 → o_zero=1.
- Busy rejection and operand capture: SLL A=1, B=3 accepted. During SHIFT drive i_valid=1 with ADD 1+1 and change i_data_a → ADD ignored; o_result=8. Holding ADD until o_ready=1 → it is accepted in the o_valid cycle and o_result=2 one cycle later.
